// File: rtl/pu_ram_resp.sv
// -----------------------------------------------------------------------------
// pu_ram_resp -- byte-lane RAM responder with a two-state request/response FSM.
//
// Storage is four independent byte banks (lane 0..3), each 2^ROW_BITS x 8.
// A request is taken on a rising edge while ready_out=1 and re_in|we_in=1.
// Stores commit on that accept edge. Loads are read on that edge and the
// response is presented one cycle later. Misaligned half/word accesses
// complete in one access. Addresses wrap modulo the capacity.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset (bank contents kept)
//   re_in, we_in   load / store request
//   width_in       00 byte, 01 half, 10 word, 11 illegal
//   uns_in         load extension: 0 sign-extend, 1 zero-extend
//   addr_in        byte address
//   wdata_in       store data, least-significant byte at addr_in
//   ready_out      responder can accept a request this cycle
//   resp_valid_out one-cycle response strobe
//   rdata_out      load data (zero for stores and errors)
//   err_out        request rejected
// -----------------------------------------------------------------------------
module pu_ram_resp #(
    parameter int ROW_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re_in,
    input  logic        we_in,
    input  logic [1:0]  width_in,
    input  logic        uns_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        ready_out,
    output logic        resp_valid_out,
    output logic [31:0] rdata_out,
    output logic        err_out
);

    localparam int DEPTH = 1 << ROW_BITS;
    localparam int HI_W  = 30 - ROW_BITS;
    localparam logic [ROW_BITS-1:0] ROW_ONE = {{(ROW_BITS-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]          state_r;
    logic                accept_s;
    logic                err_s;
    logic                is_store_s;
    logic [2:0]          nbytes_s;
    logic [1:0]          off_s;
    logic [ROW_BITS-1:0] base_row_s;
    logic [ROW_BITS-1:0] row_s     [4];
    logic [1:0]          k_s       [4];
    logic [3:0]          wr_en_s;
    logic [7:0]          wbyte_s   [4];
    logic [7:0]          rd_byte_s [4];
    logic [31:0]         raw_s;
    logic [31:0]         load_s;
    logic [31:0]         rdata_next_s;

    assign off_s      = addr_in[1:0];
    assign base_row_s = addr_in[ROW_BITS+1:2];

    // Any address bit above the capacity makes the request illegal, so the
    // wrap-around only ever applies to in-range base addresses.
    assign err_s = (width_in == 2'b11) | (re_in & we_in) |
                   (addr_in[31:ROW_BITS+2] != {HI_W{1'b0}});

    // rst gating keeps a request held during reset from touching the banks.
    assign accept_s   = (state_r == ST_IDLE) & (re_in | we_in) & ~rst;
    assign is_store_s = accept_s & we_in & ~err_s;

    // Access size in bytes.
    always_comb begin
        nbytes_s = 3'd1;
        case (width_in)
            2'b00:   nbytes_s = 3'd1;
            2'b01:   nbytes_s = 3'd2;
            2'b10:   nbytes_s = 3'd4;
            default: nbytes_s = 3'd0;
        endcase
    end

    // Per-lane byte offset, row address, write enable and write byte.
    // Lanes below the start lane belong to the next row (the access wrapped
    // past lane 3), which also wraps the row modulo the bank depth.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            k_s[l] = 2'(l) - off_s;
            if (2'(l) < off_s) begin
                row_s[l] = base_row_s + ROW_ONE;
            end else begin
                row_s[l] = base_row_s;
            end
            wr_en_s[l] = is_store_s & ({1'b0, k_s[l]} < nbytes_s);
            wbyte_s[l] = wdata_in[{k_s[l], 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem_r [DEPTH];

        // Byte bank write; contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (wr_en_s[g]) begin
                mem_r[row_s[g]] <= wbyte_s[g];
            end
        end

        assign rd_byte_s[g] = mem_r[row_s[g]];
    end

    // Rotate lanes into access order and apply size / extension, so the
    // response is fully resolved at the accept edge.
    always_comb begin
        raw_s = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            raw_s[8*k +: 8] = rd_byte_s[2'(off_s + 2'(k))];
        end
        load_s = raw_s;
        case (width_in)
            2'b00:   load_s = {{24{~uns_in & raw_s[7]}},  raw_s[7:0]};
            2'b01:   load_s = {{16{~uns_in & raw_s[15]}}, raw_s[15:0]};
            default: load_s = raw_s;
        endcase
        if (err_s || we_in) begin
            rdata_next_s = 32'h0000_0000;
        end else begin
            rdata_next_s = load_s;
        end
    end

    // Request/response FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            ready_out      <= 1'b1;
            resp_valid_out <= 1'b0;
            rdata_out      <= 32'h0000_0000;
            err_out        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r        <= ST_RESP;
                        ready_out      <= 1'b0;
                        resp_valid_out <= 1'b1;
                        rdata_out      <= rdata_next_s;
                        err_out        <= err_s;
                    end else begin
                        state_r        <= ST_IDLE;
                        ready_out      <= 1'b1;
                        resp_valid_out <= 1'b0;
                        rdata_out      <= 32'h0000_0000;
                        err_out        <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    ready_out      <= 1'b1;
                    resp_valid_out <= 1'b0;
                    rdata_out      <= 32'h0000_0000;
                    err_out        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_ram_resp.sv
// -----------------------------------------------------------------------------
// tb_pu_ram_resp -- self-checking bench for pu_ram_resp (ROW_BITS = 6).
// A byte-array model predicts acceptance, responses and memory contents;
// a negedge compare process checks the DUT every cycle, and directed
// sequences pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_pu_ram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re_in = 1'b0;
    logic        we_in = 1'b0;
    logic [1:0]  width_in = 2'b00;
    logic        uns_in = 1'b0;
    logic [31:0] addr_in = 32'h0;
    logic [31:0] wdata_in = 32'h0;
    logic        ready_out;
    logic        resp_valid_out;
    logic [31:0] rdata_out;
    logic        err_out;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0]  mem [256];
    bit          m_ready = 1'b1;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_err = 1'b0;

    pu_ram_resp #(.ROW_BITS(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .re_in          (re_in),
        .we_in          (we_in),
        .width_in       (width_in),
        .uns_in         (uns_in),
        .addr_in        (addr_in),
        .wdata_in       (wdata_in),
        .ready_out      (ready_out),
        .resp_valid_out (resp_valid_out),
        .rdata_out      (rdata_out),
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Predict what the coming rising edge does with the inputs now applied.
    task automatic model_step();
        bit          acc;
        bit          e;
        int          n;
        logic [31:0] v;
        acc = m_ready && (re_in || we_in);
        if (acc) begin
            e = (width_in == 2'd3) || (re_in && we_in) || (addr_in[31:8] != 24'h0);
            n = (width_in == 2'd0) ? 1 : (width_in == 2'd1) ? 2 : 4;
            v = 32'h0;
            if (!e && we_in) begin
                for (int k = 0; k < n; k++) mem[8'(addr_in + 32'(k))] = wdata_in[8*k +: 8];
            end else if (!e) begin
                for (int k = 0; k < n; k++) v[8*k +: 8] = mem[8'(addr_in + 32'(k))];
                if (!uns_in && n < 4 && v[8*n-1]) begin
                    for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
                end
            end
            exp_rdata = v;
            exp_err   = e;
        end
        exp_valid = acc;
        m_ready   = !acc;
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 32'(ready_out), 32'd1);
            chk("rst_valid", 32'(resp_valid_out), 32'd0);
            chk("rst_rdata", rdata_out, 32'h0);
            chk("rst_err", 32'(err_out), 32'd0);
            m_ready   = 1'b1;
            exp_valid = 1'b0;
        end else begin
            chk("ready", 32'(ready_out), 32'(m_ready));
            chk("resp_valid", 32'(resp_valid_out), 32'(exp_valid));
            if (exp_valid) begin
                chk("rdata", rdata_out, exp_rdata);
                chk("err", 32'(err_out), 32'(exp_err));
            end
            model_step();
        end
    end

    // One request; optionally checks the response against literal values.
    task automatic req(input bit re, input bit we, input logic [1:0] w, input bit u,
                       input logic [31:0] a, input logic [31:0] d, input bit lit,
                       input logic [31:0] exp_d, input bit exp_e, input string name);
        int tries = 0;
        @(posedge clk); #2;
        re_in = re; we_in = we; width_in = w; uns_in = u; addr_in = a; wdata_in = d;
        @(negedge clk);
        while (ready_out !== 1'b1 && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        chk({name, "_ready_wait"}, 32'(tries < 8), 32'd1);
        @(posedge clk); #2;
        re_in = 1'b0; we_in = 1'b0;
        @(negedge clk);
        if (lit) begin
            chk({name, "_valid"}, 32'(resp_valid_out), 32'd1);
            chk({name, "_rdata"}, rdata_out, exp_d);
            chk({name, "_err"}, 32'(err_out), 32'(exp_e));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Preload every byte through word stores.
        for (int i = 0; i < 64; i++) req(1'b0, 1'b1, 2'b10, 1'b0, 32'(4*i), $urandom, 1'b0, 32'h0, 1'b0, "pre");

        // Store/load word
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0C, 32'h01020304, 1'b1, 32'h0, 1'b0, "st_w0c");
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b1, 32'h01020304, 1'b0, "ld_w0c");

        // Sign / zero extension
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h08, 32'hDEADBE80, 1'b1, 32'h0, 1'b0, "st_b08");
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h09, 32'h1111117F, 1'b1, 32'h0, 1'b0, "st_b09");
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h08, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, "ld_bs08");
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'h08, 32'h0, 1'b1, 32'h00000080, 1'b0, "ld_bu08");
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 1'b1, 32'h00007F80, 1'b0, "ld_hs08");

        // Wrap-around word at the top of memory
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'hFF, 32'hAABBCCDD, 1'b1, 32'h0, 1'b0, "st_wff");
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'hFF, 32'h0, 1'b1, 32'hAABBCCDD, 1'b0, "ld_wff");
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'hFF, 32'h0, 1'b1, 32'h000000DD, 1'b0, "ld_bff");
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'h00, 32'h0, 1'b1, 32'h000000CC, 1'b0, "ld_b00");
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'h01, 32'h0, 1'b1, 32'h000000BB, 1'b0, "ld_b01");
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h02, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0, "ld_b02");

        // Misaligned half store leaves neighbours untouched
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h04, 32'h00000044, 1'b1, 32'h0, 1'b0, "st_b04");
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h07, 32'h00000077, 1'b1, 32'h0, 1'b0, "st_b07");
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFF1234, 1'b1, 32'h0, 1'b0, "st_h05");
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b1, 32'h77123444, 1'b0, "ld_w04");

        // Error requests: no write, zero data
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h55667788, 1'b1, 32'h0, 1'b0, "st_w10");
        req(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h00000000, 1'b1, 32'h0, 1'b1, "err_w11");
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h00000000, 1'b1, 32'h0, 1'b1, "err_rewe");
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h110, 32'h00000000, 1'b1, 32'h0, 1'b1, "err_addr_st");
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1, "err_addr_ld");
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h55667788, 1'b0, "ld_w10");

        // Back-to-back held request: ready toggles, one response per two cycles
        @(posedge clk); #2;
        re_in = 1'b1; we_in = 1'b0; width_in = 2'b10; uns_in = 1'b0; addr_in = 32'h0C;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("tput_ready", 32'(ready_out), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("tput_valid", 32'(resp_valid_out), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1) chk("tput_rdata", rdata_out, 32'h01020304);
        end
        @(posedge clk); #2;
        re_in = 1'b0;

        // Reset during RESP: response dropped, committed store kept
        @(posedge clk); #2;
        re_in = 1'b0; we_in = 1'b1; width_in = 2'b10; addr_in = 32'h20; wdata_in = 32'hCAFEF00D;
        @(negedge clk);
        chk("rst_pre_ready", 32'(ready_out), 32'd1);
        @(posedge clk); #2;
        we_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_ready", 32'(ready_out), 32'd1);
        chk("rst_async_valid", 32'(resp_valid_out), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_resp", 32'(resp_valid_out), 32'd0);
        end
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, "ld_w20");

        // Random traffic; inputs change every cycle, including during RESP.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            re_in    = ($urandom_range(0, 9) < 4);
            we_in    = ($urandom_range(0, 9) < 4);
            width_in = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            uns_in   = 1'($urandom_range(0, 1));
            addr_in  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            wdata_in = $urandom;
        end
        @(posedge clk); #2;
        re_in = 1'b0; we_in = 1'b0;

        // Final sweep: every word read back and checked against the model.
        for (int i = 0; i < 64; i++) req(1'b1, 1'b0, 2'b10, 1'b0, 32'(4*i + 1), 32'h0, 1'b0, 32'h0, 1'b0, "sweep");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pu_ram_resp.md
PU_RAM_RESP -- requirements
Module: pu_ram_resp

Interface
REQ-001 SHALL have parameter ROW_BITS, default 6, row-address width of each byte bank; capacity = 4 * 2^ROW_BITS bytes (256 at default).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port re_in  input  1  load request.
REQ-005 SHALL have port we_in  input  1  store request.
REQ-006 SHALL have port width_in  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port uns_in  input  1  load extension: 0 sign-extend, 1 zero-extend.
REQ-008 SHALL have port addr_in  input  32  byte address.
REQ-009 SHALL have port wdata_in  input  32  store data, least-significant byte at addr_in.
REQ-010 SHALL have port ready_out  output  1  responder can accept a request this cycle.
REQ-011 SHALL have port resp_valid_out  output  1  one-cycle response strobe.
REQ-012 SHALL have port rdata_out  output  32  load data, valid while resp_valid_out is high.
REQ-013 SHALL have port err_out  output  1  request rejected, valid while resp_valid_out is high.

Function
REQ-014 SHALL hold storage as four byte banks (lane 0..3), each 2^ROW_BITS x 8, one independent row address per lane.
REQ-015 SHALL accept a request on a rising edge where ready_out=1 and (re_in|we_in)=1; otherwise no request is taken.
REQ-016 SHALL implement FSM states IDLE (ready_out=1) and RESP (ready_out=0): IDLE -> RESP on accept, RESP -> IDLE unconditionally after one cycle; maximum throughput one request per 2 cycles.
REQ-017 SHALL drive resp_valid_out=1 only in RESP, exactly once per accepted request, one cycle after the accept edge.
REQ-018 SHALL compute byte offset k (0..N-1, N = 1/2/4 per width) at byte address A = addr_in + k, taking lane = A[1:0], row = A[ROW_BITS+1:2]; per lane, row = base_row + 1 when lane < addr_in[1:0], else base_row.
REQ-019 SHALL wrap byte addresses modulo capacity; e.g. word at 0xFF touches 0xFF, 0x00, 0x01, 0x02.
REQ-020 SHALL allow misaligned half and word accesses, completed in a single access with no extra cycles.
REQ-021 SHALL write wdata_in byte k to address A(k) on the accept edge for stores; lanes outside the access stay unchanged.
REQ-022 SHALL sample bank data for loads on the accept edge and present it in RESP: rdata_out[8k+7:8k] = byte A(k); upper bytes filled with the sign of the top accessed byte when uns_in=0, else zero; uns_in ignored for word.
REQ-023 SHALL flag err_out=1 and perform no bank write when any of these holds: width_in=11, re_in=we_in=1, addr_in[31:ROW_BITS+2] != 0.
REQ-024 SHALL drive rdata_out=0 for store responses and error responses.
REQ-025 SHALL latch width/uns/lane-select at accept so input changes during RESP do not affect the response.

Reset
REQ-026 SHALL while rst=1 force state IDLE, ready_out=1, resp_valid_out=0, rdata_out=0, err_out=0, asynchronously.
REQ-027 SHALL NOT clear bank contents on reset; contents are preloaded by the bench.
REQ-028 SHALL discard any pending response when rst asserts during RESP; no resp_valid_out after reset release for that request; a store already committed on its accept edge remains.

Verification
REQ-029 SHALL pass: store word 0x01020304 at 0x0C, load word 0x0C -> resp_valid_out one cycle after accept, rdata_out=0x01020304, err_out=0.
REQ-030 SHALL pass: preload byte 0x08=0x80; load byte uns_in=0 -> 0xFFFFFF80; uns_in=1 -> 0x00000080; half at 0x08 with 0x09=0x7F -> 0x00007F80.
REQ-031 SHALL pass: store word 0xAABBCCDD at 0xFF, load word 0xFF -> 0xAABBCCDD; bytes 0xFF/0x00/0x01/0x02 = DD/CC/BB/AA.
REQ-032 SHALL pass: store half 0x1234 at 0x05 -> bytes 0x05=34, 0x06=12, bytes 0x04 and 0x07 unchanged.
REQ-033 SHALL pass: requests with width=11, re=we=1, addr=0x100 -> each err_out=1, rdata_out=0, memory unchanged.
REQ-034 SHALL pass: requests held on every cycle -> ready_out toggles 1,0,1,0, one resp per two cycles; rst asserted in RESP -> resp_valid_out stays 0, ready_out=1 immediately.
